// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the round-robin selector arbiter: FSM states, requester index, count.
// Imported by the arbiter top.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/selector4.sv
// 4:1 single-bit data selector; purely combinational, zero latency.
// No flow control: output follows d and the select lines directly.
module selector4 (
    input  logic [3:0] d,
    input  logic       sel0,
    input  logic       sel1,
    output logic       y
);

    assign y = d[{sel1, sel0}];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 selector among four requesters with bounded hold.
// Grant appears 1 cycle after request; every handoff passes through one IDLE cycle.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] grant,
    output logic       sel0,
    output logic       sel1,
    output logic       dout,
    output logic       busy,
    output logic       timeout
);

    state_t             state, state_nxt;
    req_idx_t           owner, owner_nxt;
    req_idx_t           ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               timeout_nxt;
    logic [2:0]         pick;

    // Returns {valid, index} of the first set request scanning ptr, ptr+1, ...
    function automatic logic [2:0] rr_pick(input req_idx_t p, input logic [3:0] r);
        logic [2:0] res;
        req_idx_t   idx;
        res = 3'b000;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + req_idx_t'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick = rr_pick(ptr, req);

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick[2]) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick[1:0];
                    cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                // Voluntary release is tested first so it masks a coincident timeout.
                if (!req[owner]) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = owner + 2'd1;
                end else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_nxt   = ST_IDLE;
                    ptr_nxt     = owner + 2'd1;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    // owner only changes on a new grant, so the select lines hold through IDLE.
    assign busy  = (state == ST_GRANT);
    assign grant = busy ? (4'b0001 << owner) : 4'b0000;
    assign sel0  = owner[0];
    assign sel1  = owner[1];

    selector4 u_sel (
        .d    (din),
        .sel0 (sel0),
        .sel1 (sel1),
        .y    (dout)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter against a cycle-level reference model.
module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic       sel0, sel1, dout, busy, timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: owner = -1 when idle, held = cycles the grant has been visible.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_sel;
    bit m_to;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .grant   (grant),
        .sel0    (sel0),
        .sel1    (sel1),
        .dout    (dout),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_edge(input logic rn, input logic [3:0] r);
        bit found;
        int idx;
        m_to = 1'b0;
        if (!rn) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && r[idx]) begin
                    found = 1'b1; m_owner = idx; m_held = 1; m_sel = idx;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; m_to = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant", {4'b0, grant}, {4'b0, eg});
        chk("sel", {6'b0, sel1, sel0}, 8'(m_sel));
        chk("busy", {7'b0, busy}, {7'b0, m_owner >= 0});
        chk("timeout", {7'b0, timeout}, {7'b0, m_to});
        if (m_owner >= 0) chk("dout", {7'b0, dout}, {7'b0, din[m_sel]});
    endtask

    // Drive inputs, clock once, advance model, then sample 1 time unit after the edge.
    task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] d);
        rst_n = rn; req = r; din = d;
        @(posedge clk);
        model_edge(rn, r);
        #1;
        check_all();
    endtask

    logic [3:0] g_seen;
    logic [1:0] s_seen;
    int         to_cnt;

    initial begin
        m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_to = 0;
        rst_n = 1'b0; req = 4'b0; din = 4'b0;
        #1;

        // Reset then single requester
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        chk("rst_grant", {4'b0, grant}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        step(1'b1, 4'b0100, 4'b0100);
        chk("t1_grant", {4'b0, grant}, 8'h04);
        chk("t1_sel", {6'b0, sel1, sel0}, 8'h02);
        chk("t1_dout", {7'b0, dout}, 8'h01);
        step(1'b1, 4'b0000, 4'b0000);
        chk("t1_release", {4'b0, grant}, 8'h00);

        // Round-robin fairness with all requesting: ptr is 3, so owner 3 first
        to_cnt = 0;
        for (int i = 0; i < 5 * (MAX_HOLD + 1); i++) begin
            step(1'b1, 4'b1111, 4'($urandom));
            if (timeout) to_cnt++;
        end
        chk("t2_timeouts", 8'(to_cnt), 8'd5);

        // Voluntary release and pointer
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0010, 4'b0000);
        step(1'b1, 4'b0010, 4'b0010);
        step(1'b1, 4'b0010, 4'b0010);
        step(1'b1, 4'b1001, 4'b0000);
        chk("t3_gap", {4'b0, grant}, 8'h00);
        chk("t3_noto", {7'b0, timeout}, 8'h00);
        step(1'b1, 4'b1001, 4'b1000);
        chk("t3_next", {4'b0, grant}, 8'h08);
        step(1'b1, 4'b0000, 4'b0000);

        // Release coincides with the last allowed hold cycle
        step(1'b1, 4'b0001, 4'b0001);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(1'b1, 4'b0001, 4'b0001);
        step(1'b1, 4'b0000, 4'b0000);
        chk("t4_grant", {4'b0, grant}, 8'h00);
        chk("t4_noto", {7'b0, timeout}, 8'h00);

        // Reset mid-grant
        step(1'b1, 4'b0010, 4'b0000);
        chk("t5_pre", {4'b0, grant}, 8'h02);
        step(1'b0, 4'b0010, 4'b0000);
        chk("t5_grant", {4'b0, grant}, 8'h00);
        chk("t5_sel", {6'b0, sel1, sel0}, 8'h00);
        step(1'b1, 4'b0110, 4'b0010);
        chk("t5_after", {4'b0, grant}, 8'h02);
        step(1'b1, 4'b0000, 4'b0000);

        // Non-owner noise while owner 2 holds
        step(1'b1, 4'b0100, 4'b0100);
        g_seen = grant; s_seen = {sel1, sel0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i % 2 == 0) ? 4'b1101 : 4'b0100, 4'($urandom));
            chk("t6_grant", {4'b0, grant}, {4'b0, g_seen});
            chk("t6_sel", {6'b0, sel1, sel0}, {6'b0, s_seen});
        end
        step(1'b1, 4'b1001, 4'b0000);
        chk("t6_release", {4'b0, grant}, 8'h00);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) != 0), 4'($urandom), 4'($urandom));
            chk("onehot", {7'b0, $countones(grant) <= 1}, 8'h01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog observed timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
